world_clock_multizone: RTL and testbench
========================================

Name: world_clock_multizone

Overview:
- Parametrised successor to the fixed two-zone 24-hour clock pair: one base (UTC) time-of-day counter plus NUM_ZONES independently programmable minute-granular offsets.
- Presents the currently selected zone's hours/minutes, and its day shift relative to base, to the display mux.
- Emits hour and midnight pulses for the calendar.
- Sits between the 1 Hz divider and the mux/digit-display path.

Parameters:
- NUM_ZONES, 4, number of zones (2..16); ZW = max(1, clog2(NUM_ZONES)) is a derived localparam.
- TICKS_PER_MIN, 60, tick pulses per base minute; benches shrink it.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- tick  in  1  1 Hz enable pulse, one clk wide.
- set_en  in  1  load base time.
- set_hour  in  5  base hour to load, 0..23.
- set_min  in  6  base minute to load, 0..59.
- cfg_we  in  1  write a zone offset.
- cfg_zone  in  ZW  zone index to write.
- cfg_offset  in  11  signed two's-complement offset in minutes, legal -720..+840.
- zone_next  in  1  pulse: advance the displayed zone.
- zone_sel  out  ZW  currently displayed zone.
- hours  out  5  selected zone hour.
- minutes  out  6  selected zone minute.
- day_shift  out  2  zone date vs base: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
- cycle  out  1  pulse on base hour rollover.
- midnight  out  1  pulse on base 23:59 -> 00:00.

Behaviour:
- Reset (synchronous, active-high) clears everything: sub-minute count = 0, base 00:00, all offsets = 0, zone_sel = 0, hours = 0, minutes = 0, day_shift = 00, cycle = 0, midnight = 0.
- Base counter: each tick increments the sub-minute count 0..TICKS_PER_MIN-1.
  - At the wrap the minute increments 0..59.
  - At the minute wrap the hour increments 0..23, wrapping to 0.
- set_en:
  - Loads set_hour/set_min and clears the sub-minute count.
  - Has priority over a tick in the same cycle; that tick is discarded.
  - If set_hour > 23 or set_min > 59, the whole load is ignored and state is unchanged.
  - A set never produces cycle or midnight.
- cfg_we: writes cfg_offset into offset[cfg_zone].
  - Ignored if cfg_zone >= NUM_ZONES.
  - Ignored if the offset is outside -720..+840.
  - Independent of set_en, tick and zone_next in the same cycle.
- zone_next: zone_sel increments, wrapping from NUM_ZONES-1 to 0.
- Zone arithmetic (selected zone only):
  - t = base_hour*60 + base_min + offset[zone_sel], computed in signed 13-bit.
  - If t < 0: t += 1440 and day_shift = -1.
  - If t >= 1440: t -= 1440 and day_shift = +1.
  - Otherwise day_shift = 0.
  - hours = t / 60, minutes = t % 60. Any synthesizable divide is acceptable, provided it is combinational within one cycle.
- Latency: hours, minutes and day_shift are registered. They reflect new state exactly 1 clk after the edge that updates base time, zone_sel or the selected zone's offset.
- cycle: asserted for exactly 1 clk, in the same cycle the registered outputs first show the base minute rolling 59 -> 0.
- midnight: asserted together with cycle when the base hour also rolls 23 -> 0.
- Reset mid-operation: all state returns to reset values on that edge; any pending pulse is dropped.

Optional Feature:
- Macro: WCLK_12H_EN.
- Defined:
  - hours is presented in 12-hour form: 0 -> 12, 13..23 -> 1..11.
  - An extra output port pm (1 bit) = 1 when the zone hour is 12..23.
  - pm resets to 0.
  - pm has the same latency as hours.
  - day_shift is unaffected.
- Undefined: hours is 0..23 and the pm port does not exist.

Test Plan:
- Reset, then 60 ticks (TICKS_PER_MIN = 60) -> hours = 0, minutes = 1, zone_sel = 0, day_shift = 00, no cycle pulse.
- set 23:59, then 60 ticks -> hours = 0, minutes = 0; cycle and midnight both high for exactly one clk, 1 clk after the 60th tick.
- cfg zone1 offset +330, set 20:00, one zone_next -> zone_sel = 1, hours = 1, minutes = 30, day_shift = 01.
- cfg zone2 offset -300, set 02:15, select zone 2 -> hours = 21, minutes = 15, day_shift = 11.
- set_en = 1 with 10:20 in the same cycle as a tick -> 10:20 loaded and sub-minute count = 0 (next minute change after 60 further ticks); set 24:00 -> ignored, time unchanged.
- NUM_ZONES = 4, zone_next x4 -> zone_sel back to 0; cfg_offset = +900 -> ignored, offset stays 0; cfg_zone = 4 with NUM_ZONES = 4 -> ignored.

Source files
------------

// File: rtl/world_clock_multizone.sv
// world_clock_multizone: base UTC clock plus NUM_ZONES minute offsets, registered zone display with hour/midnight pulses.
// Optional 12-hour presentation with pm output under macro WCLK_12H_EN.
module world_clock_multizone #(
  parameter int NUM_ZONES = 4,
  parameter int TICKS_PER_MIN = 60,
  localparam int ZW = (NUM_ZONES < 3) ? 1 : $clog2(NUM_ZONES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          set_en,
  input  logic [4:0]    set_hour,
  input  logic [5:0]    set_min,
  input  logic          cfg_we,
  input  logic [ZW-1:0] cfg_zone,
  input  logic [10:0]   cfg_offset,
  input  logic          zone_next,
  output logic [ZW-1:0] zone_sel,
  output logic [4:0]    hours,
  output logic [5:0]    minutes,
  output logic [1:0]    day_shift,
  output logic          cycle,
`ifdef WCLK_12H_EN
  output logic          pm,
`endif
  output logic          midnight
);
  localparam int SW = (TICKS_PER_MIN < 3) ? 1 : $clog2(TICKS_PER_MIN);
  logic [SW-1:0] sub;
  logic [5:0] bmin;
  logic [4:0] bhour;
  logic signed [10:0] offset [NUM_ZONES];
  logic sub_wrap, hour_wrap, day_wrap, set_ok, cfg_ok, roll_q, mid_q;
  logic [10:0] base_mins, tn;
  logic signed [10:0] off_sel;
  logic signed [12:0] t_raw, t_n;
  logic [4:0] h24, h_out;
  logic [5:0] t_min;
  logic [1:0] ds;
  always_comb begin
    sub_wrap = tick && !set_en && sub == SW'(TICKS_PER_MIN - 1);
    hour_wrap = sub_wrap && bmin == 6'd59;
    day_wrap = hour_wrap && bhour == 5'd23;
    set_ok = set_hour <= 5'd23 && set_min <= 6'd59;
    cfg_ok = cfg_we && {1'b0, cfg_zone} < (ZW + 1)'(NUM_ZONES)
             && $signed(cfg_offset) >= -11'sd720 && $signed(cfg_offset) <= 11'sd840;
    off_sel = offset[zone_sel];
    base_mins = 11'(bhour) * 11'd60 + 11'(bmin);
    t_raw = $signed({2'b00, base_mins}) + $signed({{2{off_sel[10]}}, off_sel});
    t_n = t_raw[12] ? t_raw + 13'sd1440 : (t_raw >= 13'sd1440 ? t_raw - 13'sd1440 : t_raw);
    ds = t_raw[12] ? 2'b11 : (t_raw >= 13'sd1440 ? 2'b01 : 2'b00);
    tn = t_n[10:0];
    h24 = 5'(tn / 11'd60);
    t_min = 6'(tn % 11'd60);
`ifdef WCLK_12H_EN
    h_out = h24 == 5'd0 ? 5'd12 : (h24 > 5'd12 ? h24 - 5'd12 : h24);
`else
    h_out = h24;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sub <= '0;
      bmin <= '0;
      bhour <= '0;
      zone_sel <= '0;
      hours <= '0;
      minutes <= '0;
      day_shift <= '0;
      cycle <= 1'b0;
      midnight <= 1'b0;
      roll_q <= 1'b0;
      mid_q <= 1'b0;
`ifdef WCLK_12H_EN
      pm <= 1'b0;
`endif
      for (int i = 0; i < NUM_ZONES; i++) offset[i] <= '0;
    end else begin
      if (set_en) begin
        if (set_ok) begin
          bhour <= set_hour;
          bmin <= set_min;
          sub <= '0;
        end
      end else if (tick) begin
        sub <= sub_wrap ? '0 : sub + 1'b1;
        if (sub_wrap) bmin <= bmin == 6'd59 ? 6'd0 : bmin + 6'd1;
        if (hour_wrap) bhour <= bhour == 5'd23 ? 5'd0 : bhour + 5'd1;
      end
      if (cfg_ok) offset[cfg_zone] <= cfg_offset;
      if (zone_next) zone_sel <= zone_sel == ZW'(NUM_ZONES - 1) ? '0 : zone_sel + 1'b1;
      // Rollover is flagged one edge early so the pulse lines up with the registered display.
      roll_q <= hour_wrap;
      mid_q <= day_wrap;
      cycle <= roll_q;
      midnight <= mid_q;
      hours <= h_out;
      minutes <= t_min;
      day_shift <= ds;
`ifdef WCLK_12H_EN
      pm <= h24 >= 5'd12;
`endif
    end
  end
endmodule

// File: tb/tb_world_clock_multizone.sv
// tb_world_clock_multizone: directed checks of base counting, set/cfg rules, zone arithmetic and rollover pulses.
module tb_world_clock_multizone;
  logic clk = 0, reset = 0, tick = 0, set_en = 0, cfg_we = 0, zone_next = 0;
  logic [4:0] set_hour = 0;
  logic [5:0] set_min = 0;
  logic [1:0] cfg_zone = 0;
  logic [10:0] cfg_offset = 0;
  logic [1:0] zone_sel, day_shift;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic cycle, midnight;
  int n_chk = 0, n_pass = 0, cyc_seen = 0, mid_seen = 0;

  world_clock_multizone #(.NUM_ZONES(4), .TICKS_PER_MIN(60)) dut (
    .clk(clk), .reset(reset), .tick(tick), .set_en(set_en), .set_hour(set_hour),
    .set_min(set_min), .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_offset(cfg_offset),
    .zone_next(zone_next), .zone_sel(zone_sel), .hours(hours), .minutes(minutes),
    .day_shift(day_shift), .cycle(cycle), .midnight(midnight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (cycle) cyc_seen++;
    if (midnight) mid_seen++;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1;
      cyc();
      tick = 0;
      cyc();
    end
  endtask

  task automatic set_time(input int h, input int m);
    set_en = 1;
    set_hour = 5'(h);
    set_min = 6'(m);
    cyc();
    set_en = 0;
    cyc();
  endtask

  task automatic cfg(input int z, input int off);
    cfg_we = 1;
    cfg_zone = 2'(z);
    cfg_offset = 11'(off);
    cyc();
    cfg_we = 0;
    cyc();
  endtask

  task automatic next_zone();
    zone_next = 1;
    cyc();
    zone_next = 0;
    cyc();
  endtask

  task automatic show(input string tag, input int h, input int m, input int d);
    chk({tag, " hours"}, hours, h);
    chk({tag, " minutes"}, minutes, m);
    chk({tag, " day_shift"}, day_shift, d);
  endtask

  initial begin
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    show("reset", 0, 0, 0);
    chk("reset zone_sel", zone_sel, 0);
    chk("reset cycle", cycle, 0);
    chk("reset midnight", midnight, 0);

    cyc_seen = 0;
    ticks(60);
    show("one minute", 0, 1, 0);
    chk("one minute zone_sel", zone_sel, 0);
    chk("one minute no cycle", cyc_seen, 0);

    set_time(23, 59);
    show("set 23:59", 23, 59, 0);
    cyc_seen = 0;
    mid_seen = 0;
    ticks(59);
    chk("pre-roll no cycle", cyc_seen, 0);
    tick = 1;
    cyc();
    tick = 0;
    chk("roll edge cycle", cycle, 0);
    chk("roll edge hours", hours, 23);
    cyc();
    show("midnight", 0, 0, 0);
    chk("midnight cycle", cycle, 1);
    chk("midnight pulse", midnight, 1);
    cyc();
    chk("cycle one clk", cycle, 0);
    chk("midnight one clk", midnight, 0);
    chk("cycle count", cyc_seen, 1);
    chk("midnight count", mid_seen, 1);

    cfg_we = 1;
    cfg_zone = 1;
    cfg_offset = 11'(330);
    set_en = 1;
    set_hour = 20;
    set_min = 0;
    cyc();
    cfg_we = 0;
    set_en = 0;
    cyc();
    show("zone0 20:00", 20, 0, 0);
    next_zone();
    chk("zone1 sel", zone_sel, 1);
    show("zone1 +330", 1, 30, 1);

    cfg(2, -300);
    set_time(2, 15);
    next_zone();
    chk("zone2 sel", zone_sel, 2);
    show("zone2 -300", 21, 15, 3);
    next_zone();
    chk("zone3 sel", zone_sel, 3);
    next_zone();
    chk("zone wrap sel", zone_sel, 0);
    show("zone0 02:15", 2, 15, 0);

    cyc_seen = 0;
    set_en = 1;
    tick = 1;
    set_hour = 10;
    set_min = 20;
    cyc();
    set_en = 0;
    tick = 0;
    cyc();
    show("set over tick", 10, 20, 0);
    ticks(59);
    show("59 ticks after set", 10, 20, 0);
    ticks(1);
    show("60 ticks after set", 10, 21, 0);
    chk("no cycle on set", cyc_seen, 0);

    set_time(24, 0);
    show("set 24:00 ignored", 10, 21, 0);
    set_time(12, 60);
    show("set 12:60 ignored", 10, 21, 0);

    cfg(0, 900);
    show("cfg +900 ignored", 10, 21, 0);
    cfg(0, -721);
    show("cfg -721 ignored", 10, 21, 0);
    cfg(3, 840);

    next_zone();
    show("zone1 kept", 15, 51, 0);
    next_zone();
    show("zone2 kept", 5, 21, 0);
    next_zone();
    show("zone3 +840", 0, 21, 1);
    cfg(3, -720);
    show("zone3 -720", 22, 21, 3);
    next_zone();
    chk("zone wrap again", zone_sel, 0);

    next_zone();
    reset = 1;
    cyc();
    reset = 0;
    show("mid reset", 0, 0, 0);
    chk("mid reset zone_sel", zone_sel, 0);
    next_zone();
    set_time(20, 0);
    show("offset cleared", 20, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
